// File: rtl/issue_queue_pkg.sv
// Shared types for the issue queue slice.
//   PC_set      : one decoded instruction as handed from decode to issue,
//                 o_valid is only meaningful on the queue outputs.
//   iq_entry_t  : one queue storage slot.
//   INST_ALU / INST_DIV : inst_type encodings used by the pairing rules.
package issue_queue_pkg;

    localparam logic [9:0] INST_ALU = 10'h001;
    localparam logic [9:0] INST_DIV = 10'h008;

    typedef struct packed {
        logic [31:0] pc;
        logic [9:0]  inst_type;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic        o_valid;
    } PC_set;

    typedef PC_set iq_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// Decode -> issue queue -> EX register bundle.
//   master : decode/control side (drives instructions, flush, stalls;
//            sees in_ready and the issued pair)
//   slave  : the issue queue itself
interface issue_queue_if;
    import issue_queue_pkg::*;

    PC_set in_set1;
    PC_set in_set2;
    logic  in_valid1;
    logic  in_valid2;
    logic  in_ready;
    logic  flush_BR;
    logic  stall_DCache;
    logic  stall_div;
    PC_set i_set1;
    PC_set i_set2;

    modport master (
        output in_set1, in_set2, in_valid1, in_valid2,
        output flush_BR, stall_DCache, stall_div,
        input  in_ready, i_set1, i_set2
    );

    modport slave (
        input  in_set1, in_set2, in_valid1, in_valid2,
        input  flush_BR, stall_DCache, stall_div,
        output in_ready, i_set1, i_set2
    );

endinterface

// File: rtl/issue_pair_check.sv
// Combinational dual-issue legality check for two adjacent instructions.
//   set_a   : older instruction (goes to pipe A)
//   set_b   : younger instruction (goes to pipe B)
//   pair_ok : 1 when both may issue in the same cycle
module issue_pair_check
    import issue_queue_pkg::*;
(
    input  PC_set set_a,
    input  PC_set set_b,
    output logic  pair_ok
);

    logic alu_any;
    logic both_div;
    logic raw_hit;
    logic waw_hit;

    // Pipe A only has a simple ALU, so one of the pair must be one.
    assign alu_any  = (set_a.inst_type == INST_ALU) || (set_b.inst_type == INST_ALU);
    assign both_div = (set_a.inst_type == INST_DIV) && (set_b.inst_type == INST_DIV);

    // r0 is hardwired to zero, so writes to it never create a dependence.
    assign raw_hit = set_a.rf_we && (set_a.rf_rd != 5'd0) &&
                     ((set_a.rf_rd == set_b.rf_raddr1) || (set_a.rf_rd == set_b.rf_raddr2));
    assign waw_hit = set_a.rf_we && set_b.rf_we && (set_a.rf_rd != 5'd0) &&
                     (set_a.rf_rd == set_b.rf_rd);

    assign pair_ok = alu_any && !both_div && !raw_hit && !waw_hit;

    logic unused_fields;
    assign unused_fields = ^{set_a.pc, set_a.rf_raddr1, set_a.rf_raddr2, set_a.o_valid,
                             set_b.pc, set_b.o_valid};

endmodule

// File: rtl/issue_queue.sv
// Dual-issue in-order instruction queue between decode and the EX register.
//   clk, rstn : clock, synchronous active-low reset
//   q (slave) : up to two pushes per cycle (in_set1/2, in_valid1/2, in_ready),
//               flush_BR / stall_DCache / stall_div control, and the two
//               oldest entries presented as i_set1 / i_set2 (o_valid = issue).
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rstn,
    issue_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic             push_ok;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic             out1_vld;
    logic             out2_vld;
    logic             pair_ok;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign head_p1 = head + 1'b1;
    assign tail_p1 = tail + 1'b1;

    // Room for a full pair is required; same-cycle pops are not credited.
    assign q.in_ready = rstn && (count <= CNT_W'(DEPTH - 2));
    assign push_ok    = q.in_ready && !q.flush_BR;
    assign push_n     = push_ok ? ({1'b0, q.in_valid1} + {1'b0, q.in_valid2}) : 2'd0;

    issue_pair_check u_pair_check (
        .set_a   (mem[head]),
        .set_b   (mem[head_p1]),
        .pair_ok (pair_ok)
    );

    assign out1_vld = (count != '0);
    assign out2_vld = (count >= CNT_W'(2)) && pair_ok;

    assign pop_n = (q.stall_DCache || q.stall_div || q.flush_BR) ? 2'd0 :
                   ({1'b0, out1_vld} + {1'b0, out2_vld});

    // Non-issuing slots are forced to zero so the EX stage never sees stale fields.
    always_comb begin
        q.i_set1 = '0;
        q.i_set2 = '0;
        if (out1_vld) begin
            q.i_set1         = mem[head];
            q.i_set1.o_valid = 1'b1;
        end
        if (out2_vld) begin
            q.i_set2         = mem[head_p1];
            q.i_set2.o_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.flush_BR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // Valid inputs are packed from tail, so a lone in_set2 lands at tail.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            if (q.in_valid1) begin
                mem[tail] <= q.in_set1;
            end
            if (q.in_valid2) begin
                mem[q.in_valid1 ? tail_p1 : tail] <= q.in_set2;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam logic [9:0] INST_LOAD = 10'h002;

    logic clk;
    logic rstn;
    int   pass_cnt;
    int   total_cnt;

    issue_queue_if bus ();

    issue_queue #(.DEPTH(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic PC_set mk(input logic [31:0] pc, input logic [9:0] t, input logic we,
                                 input logic [4:0] rd, input logic [4:0] ra1, input logic [4:0] ra2);
        PC_set s;
        s.pc        = pc;
        s.inst_type = t;
        s.rf_we     = we;
        s.rf_rd     = rd;
        s.rf_raddr1 = ra1;
        s.rf_raddr2 = ra2;
        s.o_valid   = 1'b0;
        return s;
    endfunction

    function automatic PC_set outv(input PC_set s);
        PC_set r;
        r = s;
        r.o_valid = 1'b1;
        return r;
    endfunction

    // Independent ALU op used for sequence tests: always dual-issuable with neighbours.
    function automatic PC_set seq_op(input int n);
        return mk(32'h1000 + 32'(n * 4), INST_ALU, 1'b1, 5'((n % 31) + 1), 5'd0, 5'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_set1      = '0;
        bus.in_set2      = '0;
        bus.in_valid1    = 1'b0;
        bus.in_valid2    = 1'b0;
        bus.flush_BR     = 1'b0;
        bus.stall_DCache = 1'b0;
        bus.stall_div    = 1'b0;
    endtask

    task automatic push_pair(input PC_set a, input PC_set b);
        bus.in_set1   = a;
        bus.in_set2   = b;
        bus.in_valid1 = 1'b1;
        bus.in_valid2 = 1'b1;
        tick();
        bus.in_valid1 = 1'b0;
        bus.in_valid2 = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        tick();
        tick();
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set1 !== PC_set'('0)) $display("FAIL reset_i_set1 got=%h want=0", bus.i_set1);
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set2 !== PC_set'('0)) $display("FAIL reset_i_set2 got=%h want=0", bus.i_set2);
        else pass_cnt++;
        rstn = 1'b1;
        tick();
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0) $display("FAIL post_reset_empty got=%b want=0", bus.i_set1.o_valid);
        else pass_cnt++;
    endtask

    task automatic test_dual_issue();
        PC_set a, b;
        a = mk(32'h100, INST_ALU, 1'b1, 5'd1, 5'd2, 5'd3);
        b = mk(32'h104, INST_ALU, 1'b1, 5'd4, 5'd5, 5'd6);
        push_pair(a, b);
        total_cnt++;
        if (bus.i_set1 !== outv(a)) $display("FAIL dual_i_set1 got=%h want=%h", bus.i_set1, outv(a));
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set2 !== outv(b)) $display("FAIL dual_i_set2 got=%h want=%h", bus.i_set2, outv(b));
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.i_set1 !== PC_set'('0) || bus.i_set2 !== PC_set'('0))
            $display("FAIL dual_drained got=%h/%h want=0/0", bus.i_set1, bus.i_set2);
        else pass_cnt++;
    endtask

    task automatic test_raw_hazard();
        PC_set a, b;
        a = mk(32'h200, INST_ALU, 1'b1, 5'd1, 5'd2, 5'd3);
        b = mk(32'h204, INST_ALU, 1'b1, 5'd7, 5'd1, 5'd0);
        push_pair(a, b);
        total_cnt++;
        if (bus.i_set1 !== outv(a)) $display("FAIL raw_c1_i_set1 got=%h want=%h", bus.i_set1, outv(a));
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set2 !== PC_set'('0)) $display("FAIL raw_c1_i_set2 got=%h want=0", bus.i_set2);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.i_set1 !== outv(b)) $display("FAIL raw_c2_i_set1 got=%h want=%h", bus.i_set1, outv(b));
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set2.o_valid !== 1'b0) $display("FAIL raw_c2_i_set2 got=%b want=0", bus.i_set2.o_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0) $display("FAIL raw_drained got=%b want=0", bus.i_set1.o_valid);
        else pass_cnt++;
    endtask

    task automatic test_pair_rules();
        PC_set d, l, a, w1, w2;
        d  = mk(32'h300, INST_DIV,  1'b1, 5'd8,  5'd9,  5'd10);
        l  = mk(32'h304, INST_LOAD, 1'b1, 5'd11, 5'd12, 5'd0);
        push_pair(d, l);
        total_cnt++;
        if (bus.i_set1 !== outv(d) || bus.i_set2.o_valid !== 1'b0)
            $display("FAIL divld_c1 got=%h/%b want=%h/0", bus.i_set1, bus.i_set2.o_valid, outv(d));
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.i_set1 !== outv(l) || bus.i_set2.o_valid !== 1'b0)
            $display("FAIL divld_c2 got=%h/%b want=%h/0", bus.i_set1, bus.i_set2.o_valid, outv(l));
        else pass_cnt++;
        tick();
        d = mk(32'h310, INST_DIV, 1'b1, 5'd8,  5'd9, 5'd10);
        a = mk(32'h314, INST_ALU, 1'b1, 5'd13, 5'd2, 5'd3);
        push_pair(d, a);
        total_cnt++;
        if (bus.i_set1 !== outv(d) || bus.i_set2 !== outv(a))
            $display("FAIL divalu_dual got=%h/%h want=%h/%h", bus.i_set1, bus.i_set2, outv(d), outv(a));
        else pass_cnt++;
        tick();
        // Same destination register in both: must split.
        w1 = mk(32'h320, INST_ALU, 1'b1, 5'd5, 5'd1, 5'd2);
        w2 = mk(32'h324, INST_ALU, 1'b1, 5'd5, 5'd3, 5'd4);
        push_pair(w1, w2);
        total_cnt++;
        if (bus.i_set1 !== outv(w1) || bus.i_set2.o_valid !== 1'b0)
            $display("FAIL waw_split got=%h/%b want=%h/0", bus.i_set1, bus.i_set2.o_valid, outv(w1));
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0) $display("FAIL rules_drained got=%b want=0", bus.i_set1.o_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        bus.stall_div = 1'b1;
        push_pair(seq_op(0), seq_op(1));
        push_pair(seq_op(2), seq_op(3));
        total_cnt++;
        if (bus.i_set1 !== outv(seq_op(0)) || bus.i_set2 !== outv(seq_op(1)))
            $display("FAIL stall_head got=%h/%h want=%h/%h", bus.i_set1, bus.i_set2,
                     outv(seq_op(0)), outv(seq_op(1)));
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) push_pair(seq_op(4), seq_op(5));
            else tick();
            total_cnt++;
            if (bus.i_set1 !== outv(seq_op(0)))
                $display("FAIL stall_hold_%0d got=%h want=%h", c, bus.i_set1, outv(seq_op(0)));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL stall_ready_at6 got=%b want=1", bus.in_ready);
        else pass_cnt++;
        bus.in_set1   = seq_op(6);
        bus.in_valid1 = 1'b1;
        tick();
        bus.in_valid1 = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_at7 got=%b want=0", bus.in_ready);
        else pass_cnt++;
        // Offered while not ready: must be ignored.
        push_pair(mk(32'hBAD0, INST_ALU, 1'b1, 5'd20, 5'd0, 5'd0),
                  mk(32'hBAD4, INST_ALU, 1'b1, 5'd21, 5'd0, 5'd0));
        bus.stall_div = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (bus.i_set1 !== outv(seq_op(2 * k + 2)))
                $display("FAIL stall_drain_%0d got=%h want=%h", k, bus.i_set1, outv(seq_op(2 * k + 2)));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.i_set2.o_valid !== 1'b0) $display("FAIL stall_drain_single got=%b want=0", bus.i_set2.o_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0) $display("FAIL stall_ignored_push got=%h want=empty", bus.i_set1);
        else pass_cnt++;
    endtask

    task automatic test_full_flush();
        bus.stall_DCache = 1'b1;
        for (int k = 0; k < 4; k++) push_pair(seq_op(10 + 2 * k), seq_op(11 + 2 * k));
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL full_ready got=%b want=0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set1 !== outv(seq_op(10))) $display("FAIL full_head got=%h want=%h", bus.i_set1, outv(seq_op(10)));
        else pass_cnt++;
        bus.flush_BR  = 1'b1;
        bus.in_set1   = mk(32'h5F0, INST_ALU, 1'b1, 5'd3, 5'd0, 5'd0);
        bus.in_valid1 = 1'b1;
        tick();
        bus.flush_BR     = 1'b0;
        bus.in_valid1    = 1'b0;
        bus.stall_DCache = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL flush_ready got=%b want=1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0 || bus.i_set2.o_valid !== 1'b0)
            $display("FAIL flush_empty got=%b/%b want=0/0", bus.i_set1.o_valid, bus.i_set2.o_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0) $display("FAIL flush_push_absent got=%h want=empty", bus.i_set1);
        else pass_cnt++;
        // Flush with room available still drops the same-cycle pair.
        bus.flush_BR = 1'b1;
        push_pair(seq_op(30), seq_op(31));
        bus.flush_BR = 1'b0;
        tick();
        total_cnt++;
        if (bus.i_set1.o_valid !== 1'b0) $display("FAIL flush_drop_pair got=%h want=empty", bus.i_set1);
        else pass_cnt++;
        // Lone in_set2 is written at tail and visible next cycle.
        bus.in_set2   = seq_op(40);
        bus.in_valid2 = 1'b1;
        tick();
        bus.in_valid2 = 1'b0;
        total_cnt++;
        if (bus.i_set1 !== outv(seq_op(40)) || bus.i_set2.o_valid !== 1'b0)
            $display("FAIL v2_only got=%h/%b want=%h/0", bus.i_set1, bus.i_set2.o_valid, outv(seq_op(40)));
        else pass_cnt++;
        tick();
    endtask

    task automatic test_wrap_order();
        int    q[$];
        int    n;
        int    pop;
        int    r;
        logic  st;
        logic  exp_ready;
        PC_set e1, e2;
        n = 100;
        q.delete();
        for (int c = 0; c < 70; c++) begin
            exp_ready = (8 - q.size()) >= 2;
            e1 = (q.size() >= 1) ? outv(seq_op(q[0])) : PC_set'('0);
            e2 = (q.size() >= 2) ? outv(seq_op(q[1])) : PC_set'('0);
            total_cnt++;
            if (bus.in_ready !== exp_ready) $display("FAIL wrap_ready_%0d got=%b want=%b", c, bus.in_ready, exp_ready);
            else pass_cnt++;
            total_cnt++;
            if (bus.i_set1 !== e1) $display("FAIL wrap_i_set1_%0d got=%h want=%h", c, bus.i_set1, e1);
            else pass_cnt++;
            total_cnt++;
            if (bus.i_set2 !== e2) $display("FAIL wrap_i_set2_%0d got=%h want=%h", c, bus.i_set2, e2);
            else pass_cnt++;
            r  = (c >= 60) ? 0 : $urandom_range(0, 3);
            st = (c >= 60) ? 1'b0 : ($urandom_range(0, 3) == 0);
            bus.stall_div = st;
            bus.in_valid1 = r[0];
            bus.in_valid2 = r[1];
            bus.in_set1   = seq_op(n);
            bus.in_set2   = seq_op(r[0] ? n + 1 : n);
            pop = st ? 0 : ((q.size() >= 2) ? 2 : q.size());
            tick();
            for (int p = 0; p < pop; p++) void'(q.pop_front());
            if (exp_ready) begin
                if (r[0]) begin q.push_back(n); n++; end
                if (r[1]) begin q.push_back(n); n++; end
            end
        end
        idle_inputs();
        total_cnt++;
        if (q.size() != 0 || bus.i_set1.o_valid !== 1'b0)
            $display("FAIL wrap_final_empty got=%b want=0 (model=%0d)", bus.i_set1.o_valid, q.size());
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_dual_issue();
        test_raw_hazard();
        test_pair_rules();
        test_stall();
        test_full_flush();
        test_wrap_order();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
